d_ff_async_reset: RTL and testbench
===================================

D_FF_ASYNC_RESET -- requirements
Module: d_ff_async_reset

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits of D, Q and not_Q.
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits): value forced onto Q while reset is asserted.
REQ-003 Port clk, input, 1 bit: the single clock; all capture occurs on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port D, input, WIDTH bits: data to be captured.
REQ-006 Port Q, output, WIDTH bits: registered data.
REQ-007 Port not_Q, output, WIDTH bits: bitwise complement of Q.

Function
REQ-008 The block SHALL load Q with D on every rising edge of clk while reset = 1.
REQ-009 The block SHALL hold Q unchanged between rising clk edges, including across falling edges and any D changes.
REQ-010 Capture latency SHALL be zero cycles: the new Q SHALL be visible immediately after the rising edge that samples D.
REQ-011 D sampled at a rising edge SHALL be the value present before that edge; a D change coincident with the edge SHALL NOT corrupt the captured value.
REQ-012 not_Q SHALL equal ~Q at all times, including during reset and during the first edge after reset release, with no extra register stage.
REQ-013 Each bit SHALL behave independently; for WIDTH > 1 bit i of Q depends only on bit i of D.
REQ-014 Q and not_Q SHALL be X/unknown before the first reset assertion or first clock edge; no power-up initial value is required.

Reset
REQ-015 When reset falls to 0, Q SHALL immediately become RESET_VALUE and not_Q SHALL immediately become ~RESET_VALUE, independent of clk.
REQ-016 While reset = 0, rising clk edges SHALL be ignored and Q SHALL stay at RESET_VALUE.
REQ-017 If reset is asserted at the same instant as a rising clk edge, reset SHALL win and Q SHALL be RESET_VALUE.
REQ-018 After reset rises to 1, Q SHALL keep RESET_VALUE until the next rising clk edge, which SHALL capture D normally.
REQ-019 The block SHALL contain no reset synchronizer; release timing relative to clk is the integrator's responsibility.

Structure
REQ-020 A shared package SHALL hold the default data width constant and the default reset value constant.
REQ-021 A single-bit sub-module d_ff_async_reset_bit (D, clk, reset, Q, not_Q, per-bit reset value) SHALL be implemented.
REQ-022 The top module SHALL instantiate WIDTH copies of the sub-module in a generate loop.
REQ-023 The design SHALL use one clock domain, with no latches and no combinational feedback.

Verification
REQ-024 Scenario: with reset=1, set D=0 and raise clk -> Q=0 and not_Q=1 after the edge.
REQ-025 Scenario: with reset=1, set D=1 at clk low, then raise clk -> Q=1 and not_Q=0; D toggling to 0 with clk held high -> Q stays 1.
REQ-026 Scenario: with Q=1 and clk high and stable, drop reset to 0 -> Q=0 and not_Q=1 immediately, with no clock edge.
REQ-027 Scenario: with reset=0 and D=1, apply 3 rising clk edges -> Q remains 0 throughout.
REQ-028 Scenario: release reset to 1 with D=1 -> Q stays 0 until the next rising edge, then Q=1.
REQ-029 Scenario: with WIDTH=4, RESET_VALUE=4'b1010, and D=4'b0101 clocked -> Q=4'b0101 and not_Q=4'b1010; assert reset -> Q=4'b1010 and not_Q=4'b0101 immediately.

Source files
------------

// File: rtl/d_ff_async_reset_pkg.sv
// Shared constants for the async-reset D flip-flop.
// Default width and per-bit reset level.
package d_ff_async_reset_pkg;

  localparam int unsigned DFF_WIDTH = 1;

  localparam logic DFF_RST_BIT = 1'b0;

  function automatic logic [DFF_WIDTH-1:0] dff_default_rst();
    return {DFF_WIDTH{DFF_RST_BIT}};
  endfunction

endpackage

// File: rtl/d_ff_async_reset_bit.sv
// Single-bit D flip-flop with async active-low reset.
// not_Q is the inverted flop output, no extra stage.
module d_ff_async_reset_bit
  import d_ff_async_reset_pkg::*;
#(
  parameter logic RST_VAL = DFF_RST_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic D,
  output logic Q,
  output logic not_Q
);

  logic q_d;
  logic q_q;

  // next state is simply the sampled data bit
  always_comb begin
    q_d = D;
  end

  // capture on rising clk, force RST_VAL while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q     = q_q;
  assign not_Q = ~q_q;

endmodule

// File: rtl/d_ff_async_reset.sv
// WIDTH-bit D flip-flop with async active-low reset.
// Built from independent single-bit cells.
module d_ff_async_reset
  import d_ff_async_reset_pkg::*;
#(
  parameter int unsigned      WIDTH       = DFF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_RST_BIT}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q
);

  // one cell per bit, each with its own reset level
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_async_reset_bit #(
      .RST_VAL (RESET_VALUE[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .D     (D[i]),
      .Q     (Q[i]),
      .not_Q (not_Q[i])
    );
  end

endmodule

// File: tb/tb_d_ff_async_reset.sv
// Directed bench for d_ff_async_reset.
// Checks a 1-bit default and a 4-bit instance.
module tb_d_ff_async_reset;

  logic       clk;
  logic       reset;
  logic       d1;
  logic       q1;
  logic       nq1;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [3:0] nq4;

  int tests;
  int fails;

  d_ff_async_reset u_dut1 (
    .clk   (clk),
    .reset (reset),
    .D     (d1),
    .Q     (q1),
    .not_Q (nq1)
  );

  d_ff_async_reset #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .D     (d4),
    .Q     (q4),
    .not_Q (nq4)
  );

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic qe);
    chk({tag, ".q"},  {3'b0, q1},  {3'b0, qe});
    chk({tag, ".nq"}, {3'b0, nq1}, {3'b0, ~qe});
  endtask

  task automatic chk4(input string tag, input logic [3:0] qe);
    chk({tag, ".q4"},  q4,  qe);
    chk({tag, ".nq4"}, nq4, ~qe);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk   = 1'b0;
    reset = 1'b1;
    d1    = 1'b1;
    d4    = 4'b1111;

    // initial reset, no clock
    #5;
    reset = 1'b0;
    #1;
    chk1("rst_init", 1'b0);
    chk4("rst_init", 4'b1010);
    #4;
    reset = 1'b1;
    #5;

    // D=0 captured
    d1 = 1'b0;
    d4 = 4'b0011;
    #5 clk = 1'b1;
    #1;
    chk1("cap0", 1'b0);
    chk4("cap0", 4'b0011);
    #4 clk = 1'b0;

    // D=1 captured, then D toggles with clk high
    #2;
    d1 = 1'b1;
    d4 = 4'b0101;
    #3 clk = 1'b1;
    #1;
    chk1("cap1", 1'b1);
    chk4("cap1", 4'b0101);
    d1 = 1'b0;
    d4 = 4'b1100;
    #2;
    chk1("hold_hi", 1'b1);
    chk4("hold_hi", 4'b0101);
    #2 clk = 1'b0;
    #1;
    chk1("hold_fall", 1'b1);

    // D changes exactly at the edge: old value must be captured
    #4;
    d1 = 1'b1;
    d4 = 4'b0110;
    #5;
    clk = 1'b1;
    d1 <= 1'b0;
    d4 <= 4'b1001;
    #1;
    chk1("coinc_d", 1'b1);
    chk4("coinc_d", 4'b0110);
    #4 clk = 1'b0;

    // async reset with clk high and stable
    d1 = 1'b1;
    d4 = 4'b0101;
    #5 clk = 1'b1;
    #1;
    chk1("pre_rst", 1'b1);
    chk4("pre_rst", 4'b0101);
    #2 reset = 1'b0;
    #1;
    chk1("async_rst", 1'b0);
    chk4("async_rst", 4'b1010);
    #2 clk = 1'b0;

    // clocks ignored in reset
    d1 = 1'b1;
    d4 = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #5 clk = 1'b1;
      #1;
      chk1("rst_clk", 1'b0);
      chk4("rst_clk", 4'b1010);
      #4 clk = 1'b0;
    end

    // release: hold until next edge
    #3 reset = 1'b1;
    #1;
    chk1("rel_hold", 1'b0);
    chk4("rel_hold", 4'b1010);
    #1 clk = 1'b1;
    #1;
    chk1("rel_cap", 1'b1);
    chk4("rel_cap", 4'b1111);
    #4 clk = 1'b0;

    // reset coincident with rising edge: reset wins
    d1 = 1'b1;
    d4 = 4'b0001;
    #5;
    clk   = 1'b1;
    reset = 1'b0;
    #1;
    chk1("coinc_rst", 1'b0);
    chk4("coinc_rst", 4'b1010);
    #4 clk = 1'b0;
    #5;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
